// File: rtl/opnd_mem_sched_pkg.sv
// Shared types and constants for the memory-operand sequencer.
package opnd_mem_sched_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SCALE_W = 2;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ADDR0 = 2'd1,
    SCHED_ADDR1 = 2'd2,
    SCHED_DONE  = 2'd3
  } sched_state_e;

  // Address-generation fields of one operand
  typedef struct packed {
    logic [SCALE_W-1:0] scale;
    logic [DATA_W-1:0]  index;
    logic [DATA_W-1:0]  base;
    logic [DATA_W-1:0]  disp;
  } opnd_fields_t;

  // One memory hint
  typedef struct packed {
    logic              is_write;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] data;
  } hint_t;

  // A hint satisfies an address only when it is a read of exactly that address
  function automatic logic hint_hit(input hint_t h, input logic [DATA_W-1:0] addr);
    return !h.is_write && (h.address == addr);
  endfunction

endpackage

// File: rtl/opnd_mem_sched_agu.sv
// Effective-address generator: base + (index << scale) + disp, wrapping mod 2^32.
module opnd_mem_sched_agu
  import opnd_mem_sched_pkg::*;
(
  input  logic [SCALE_W-1:0] i_scale,
  input  logic [DATA_W-1:0]  i_index,
  input  logic [DATA_W-1:0]  i_base,
  input  logic [DATA_W-1:0]  i_disp,
  output logic [DATA_W-1:0]  o_addr
);

  logic [DATA_W-1:0] w_scaled;

  assign w_scaled = i_index << i_scale;
  assign o_addr   = i_base + w_scaled + i_disp;

endmodule

// File: rtl/opnd_mem_sched.sv
// Sequencer sharing one AGU between operand#0 and operand#1 address computations,
// resolving each address against two latched read hints.
module opnd_mem_sched
  import opnd_mem_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               opnd0_is_mem,
  input  logic               opnd1_is_mem,
  input  logic [SCALE_W-1:0] opnd0_scale,
  input  logic [SCALE_W-1:0] opnd1_scale,
  input  logic [DATA_W-1:0]  opnd0_index,
  input  logic [DATA_W-1:0]  opnd0_base,
  input  logic [DATA_W-1:0]  opnd0_disp,
  input  logic [DATA_W-1:0]  opnd1_index,
  input  logic [DATA_W-1:0]  opnd1_base,
  input  logic [DATA_W-1:0]  opnd1_disp,
  input  logic               hint1_is_write,
  input  logic               hint2_is_write,
  input  logic [DATA_W-1:0]  hint1_address,
  input  logic [DATA_W-1:0]  hint1_data,
  input  logic [DATA_W-1:0]  hint2_address,
  input  logic [DATA_W-1:0]  hint2_data,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  opnd0_mem_addr,
  output logic [DATA_W-1:0]  opnd1_mem_addr,
  output logic [DATA_W-1:0]  opnd0_mem_value,
  output logic [DATA_W-1:0]  opnd1_mem_value,
  output logic               opnd0_miss,
  output logic               opnd1_miss
);

  sched_state_e      r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_is_mem1;
  opnd_fields_t      r_op0;
  opnd_fields_t      r_op1;
  hint_t             r_hint1;
  hint_t             r_hint2;
  logic [DATA_W-1:0] r_addr0;
  logic [DATA_W-1:0] r_addr1;
  logic [DATA_W-1:0] r_val0;
  logic [DATA_W-1:0] r_val1;
  logic              r_miss0;
  logic              r_miss1;

  opnd_fields_t      w_sel;
  logic [DATA_W-1:0] w_agu_addr;
  logic [DATA_W-1:0] w_value;
  logic              w_miss;

  // Feed the shared AGU with the operand being resolved this cycle
  assign w_sel = (r_state == SCHED_ADDR1) ? r_op1 : r_op0;

  opnd_mem_sched_agu u_agu (
    .i_scale (w_sel.scale),
    .i_index (w_sel.index),
    .i_base  (w_sel.base),
    .i_disp  (w_sel.disp),
    .o_addr  (w_agu_addr)
  );

  // Hint match, first hint wins; no match yields value 0 and a miss
  always_comb begin
    w_value = '0;
    w_miss  = 1'b1;
    if (hint_hit(r_hint1, w_agu_addr)) begin
      w_value = r_hint1.data;
      w_miss  = 1'b0;
    end else if (hint_hit(r_hint2, w_agu_addr)) begin
      w_value = r_hint2.data;
      w_miss  = 1'b0;
    end
  end

  // Sequencer state, input latches and registered results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= SCHED_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_is_mem1 <= 1'b0;
      r_op0     <= '0;
      r_op1     <= '0;
      r_hint1   <= '0;
      r_hint2   <= '0;
      r_addr0   <= '0;
      r_addr1   <= '0;
      r_val0    <= '0;
      r_val1    <= '0;
      r_miss0   <= 1'b0;
      r_miss1   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SCHED_IDLE: begin
          if (start) begin
            r_is_mem1 <= opnd1_is_mem;
            r_op0     <= '{scale: opnd0_scale, index: opnd0_index,
                           base: opnd0_base, disp: opnd0_disp};
            r_op1     <= '{scale: opnd1_scale, index: opnd1_index,
                           base: opnd1_base, disp: opnd1_disp};
            r_hint1   <= '{is_write: hint1_is_write, address: hint1_address,
                           data: hint1_data};
            r_hint2   <= '{is_write: hint2_is_write, address: hint2_address,
                           data: hint2_data};
            r_addr0   <= '0;
            r_addr1   <= '0;
            r_val0    <= '0;
            r_val1    <= '0;
            r_miss0   <= 1'b0;
            r_miss1   <= 1'b0;
            r_busy    <= 1'b1;
            if (opnd0_is_mem) begin
              r_state <= SCHED_ADDR0;
            end else if (opnd1_is_mem) begin
              r_state <= SCHED_ADDR1;
            end else begin
              r_state <= SCHED_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        SCHED_ADDR0: begin
          r_addr0 <= w_agu_addr;
          r_val0  <= w_value;
          r_miss0 <= w_miss;
          if (r_is_mem1) begin
            r_state <= SCHED_ADDR1;
          end else begin
            r_state <= SCHED_DONE;
            r_done  <= 1'b1;
          end
        end
        SCHED_ADDR1: begin
          r_addr1 <= w_agu_addr;
          r_val1  <= w_value;
          r_miss1 <= w_miss;
          r_state <= SCHED_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= SCHED_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign opnd0_mem_addr  = r_addr0;
  assign opnd1_mem_addr  = r_addr1;
  assign opnd0_mem_value = r_val0;
  assign opnd1_mem_value = r_val1;
  assign opnd0_miss      = r_miss0;
  assign opnd1_miss      = r_miss1;

endmodule

// File: tb/tb_opnd_mem_sched.sv
// Randomized self-checking bench for opnd_mem_sched against a rule-level model.
module tb_opnd_mem_sched;

  typedef struct {
    bit          m0, m1;
    logic [1:0]  s0, s1;
    logic [31:0] i0, b0, d0, i1, b1, d1;
    bit          w1, w2;
    logic [31:0] a1, dt1, a2, dt2;
  } op_t;

  // {addr0, value0, miss0, addr1, value1, miss1}
  typedef logic [129:0] res_t;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        opnd0_is_mem, opnd1_is_mem;
  logic [1:0]  opnd0_scale, opnd1_scale;
  logic [31:0] opnd0_index, opnd0_base, opnd0_disp;
  logic [31:0] opnd1_index, opnd1_base, opnd1_disp;
  logic        hint1_is_write, hint2_is_write;
  logic [31:0] hint1_address, hint1_data, hint2_address, hint2_data;
  logic        busy, done;
  logic [31:0] opnd0_mem_addr, opnd1_mem_addr, opnd0_mem_value, opnd1_mem_value;
  logic        opnd0_miss, opnd1_miss;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  opnd_mem_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .opnd0_is_mem(opnd0_is_mem), .opnd1_is_mem(opnd1_is_mem),
    .opnd0_scale(opnd0_scale), .opnd1_scale(opnd1_scale),
    .opnd0_index(opnd0_index), .opnd0_base(opnd0_base), .opnd0_disp(opnd0_disp),
    .opnd1_index(opnd1_index), .opnd1_base(opnd1_base), .opnd1_disp(opnd1_disp),
    .hint1_is_write(hint1_is_write), .hint2_is_write(hint2_is_write),
    .hint1_address(hint1_address), .hint1_data(hint1_data),
    .hint2_address(hint2_address), .hint2_data(hint2_data),
    .busy(busy), .done(done),
    .opnd0_mem_addr(opnd0_mem_addr), .opnd1_mem_addr(opnd1_mem_addr),
    .opnd0_mem_value(opnd0_mem_value), .opnd1_mem_value(opnd1_mem_value),
    .opnd0_miss(opnd0_miss), .opnd1_miss(opnd1_miss)
  );

  // Effective address from the arithmetic definition, reduced mod 2^32
  function automatic logic [31:0] ea(input logic [31:0] b, input logic [31:0] i,
                                     input logic [1:0] s, input logic [31:0] d);
    logic [63:0] t;
    t = 64'(b) + 64'(i) * (64'd1 << s) + 64'(d);
    return t[31:0];
  endfunction

  // Value/miss resolution for one operand
  function automatic logic [64:0] resolve(input bit is_mem, input logic [31:0] a, input op_t op);
    if (!is_mem) return 65'd0;
    if (!op.w1 && op.a1 == a) return {a, op.dt1, 1'b0};
    if (!op.w2 && op.a2 == a) return {a, op.dt2, 1'b0};
    return {a, 32'd0, 1'b1};
  endfunction

  function automatic res_t model(input op_t op);
    return {resolve(op.m0, ea(op.b0, op.i0, op.s0, op.d0), op),
            resolve(op.m1, ea(op.b1, op.i1, op.s1, op.d1), op)};
  endfunction

  function automatic res_t observed();
    return {opnd0_mem_addr, opnd0_mem_value, opnd0_miss,
            opnd1_mem_addr, opnd1_mem_value, opnd1_miss};
  endfunction

  task automatic drive(input op_t op);
    opnd0_is_mem = op.m0; opnd1_is_mem = op.m1;
    opnd0_scale = op.s0; opnd0_index = op.i0; opnd0_base = op.b0; opnd0_disp = op.d0;
    opnd1_scale = op.s1; opnd1_index = op.i1; opnd1_base = op.b1; opnd1_disp = op.d1;
    hint1_is_write = op.w1; hint1_address = op.a1; hint1_data = op.dt1;
    hint2_is_write = op.w2; hint2_address = op.a2; hint2_data = op.dt2;
  endtask

  function automatic op_t scramble(input op_t op);
    op_t r;
    r = op;
    r.m0 = ~op.m0; r.m1 = ~op.m1; r.s0 = ~op.s0; r.s1 = ~op.s1;
    r.i0 = ~op.i0; r.b0 = ~op.b0; r.d0 = ~op.d0;
    r.i1 = ~op.i1; r.b1 = ~op.b1; r.d1 = ~op.d1;
    r.w1 = ~op.w1; r.w2 = ~op.w2;
    r.a1 = ~op.a1; r.dt1 = ~op.dt1; r.a2 = ~op.a2; r.dt2 = ~op.dt2;
    return r;
  endfunction

  function automatic op_t zero_op();
    op_t z;
    z = '{default: 0};
    return z;
  endfunction

  // Issue one request; returns cycles to done (0 = never), results, and the cycle after
  task automatic run_op(input op_t op, input bit glitch, output int lat,
                        output res_t res, output res_t held,
                        output logic held_done, output logic held_busy);
    int n;
    lat = 0;
    n = 0;
    @(negedge clk);
    drive(op);
    start = 1'b1;
    @(posedge clk);
    while (lat == 0 && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        drive(scramble(op));
        start = glitch;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) lat = n;
    end
    res = observed();
    @(negedge clk);
    start = 1'b0;
    held = observed();
    held_done = done;
    held_busy = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    drive(zero_op());
    opnd0_is_mem = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: busy/done=%b required 00", {busy, done});
    end
    n_checks++;
    if (observed() !== '0) begin
      n_fail++; $display("FAIL reset_results: got %h required 0", observed());
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_op(input string name, input op_t op, input bit glitch);
    int lat; res_t res, held, exp; logic hd, hb;
    exp = model(op);
    run_op(op, glitch, lat, res, held, hd, hb);
    n_checks++;
    if (lat !== 1 + int'(op.m0) + int'(op.m1)) begin
      n_fail++; $display("FAIL %s_latency: got %0d required %0d", name, lat, 1 + int'(op.m0) + int'(op.m1));
    end
    n_checks++;
    if (res !== exp) begin
      n_fail++; $display("FAIL %s_results: got %h required %h", name, res, exp);
    end
    n_checks++;
    if ({hd, hb} !== 2'b00 || held !== exp) begin
      n_fail++; $display("FAIL %s_hold: done/busy=%b res=%h required 00 %h", name, {hd, hb}, held, exp);
    end
  endtask

  task automatic test_movs();
    op_t op;
    res_t exp;
    op = zero_op();
    op.m0 = 1; op.b0 = 32'h1000; op.i0 = 32'h4; op.s0 = 2; op.d0 = 32'h10;
    op.m1 = 1; op.b1 = 32'h2000;
    op.a1 = 32'h1020; op.dt1 = 32'hAAAA; op.a2 = 32'h2000; op.dt2 = 32'hBBBB;
    exp = {32'h1020, 32'hAAAA, 1'b0, 32'h2000, 32'hBBBB, 1'b0};
    n_checks++;
    if (model(op) !== exp) begin
      n_fail++; $display("FAIL movs_model: got %h required %h", model(op), exp);
    end
    check_op("movs", op, 1'b0);
  endtask

  task automatic test_write_hint();
    op_t op;
    op = zero_op();
    op.m1 = 1; op.b1 = 32'h3000; op.i1 = 32'h8; op.s1 = 1; op.d1 = 32'h4;
    op.w1 = 1; op.a1 = 32'h3014; op.dt1 = 32'h1111;
    op.a2 = 32'h3014; op.dt2 = 32'h2222;
    check_op("write_hint", op, 1'b0);
  endtask

  task automatic test_priority();
    op_t op;
    op = zero_op();
    op.m0 = 1; op.b0 = 32'h500;
    op.a1 = 32'h500; op.dt1 = 32'h1; op.a2 = 32'h500; op.dt2 = 32'h2;
    check_op("priority", op, 1'b0);
  endtask

  task automatic test_wrap();
    op_t op;
    op = zero_op();
    op.m0 = 1; op.b0 = 32'hFFFF_FFF0; op.d0 = 32'h20;
    op.a1 = 32'h0000_0020; op.dt1 = 32'h7; op.a2 = 32'h1_0010 ; op.dt2 = 32'h8;
    check_op("wrap", op, 1'b0);
  endtask

  task automatic test_busy_start();
    op_t op;
    op = zero_op();
    op.m0 = 1; op.b0 = 32'h40; op.m1 = 1; op.b1 = 32'h80; op.i1 = 32'h3; op.s1 = 3;
    op.a1 = 32'h98; op.dt1 = 32'hC0DE; op.a2 = 32'h40; op.dt2 = 32'hBEEF;
    check_op("busy_start", op, 1'b1);
    check_op("neither", zero_op(), 1'b0);
  endtask

  task automatic test_reset_mid();
    op_t op;
    bit saw_done;
    op = zero_op();
    op.m0 = 1; op.b0 = 32'h100; op.m1 = 1; op.b1 = 32'h200;
    op.a1 = 32'h100; op.dt1 = 32'h55;
    @(negedge clk);
    drive(op);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({busy, done} !== 2'b00 || observed() !== '0) begin
      n_fail++; $display("FAIL reset_mid: busy/done=%b res=%h required 00 0", {busy, done}, observed());
    end
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++; $display("FAIL reset_mid_nodone: done=1 required 0");
    end
    check_op("after_reset", op, 1'b0);
  endtask

  task automatic test_random();
    op_t op;
    logic [31:0] e0, e1;
    for (int k = 0; k < 40; k++) begin
      op.m0 = 1'($urandom); op.m1 = 1'($urandom);
      op.s0 = 2'($urandom); op.s1 = 2'($urandom);
      op.i0 = $urandom; op.b0 = $urandom; op.d0 = $urandom;
      op.i1 = $urandom; op.b1 = $urandom; op.d1 = $urandom;
      op.w1 = ($urandom_range(3) == 0); op.w2 = ($urandom_range(3) == 0);
      op.dt1 = $urandom; op.dt2 = $urandom;
      e0 = ea(op.b0, op.i0, op.s0, op.d0);
      e1 = ea(op.b1, op.i1, op.s1, op.d1);
      case ($urandom_range(2))
        0: op.a1 = e0;
        1: op.a1 = e1;
        default: op.a1 = $urandom;
      endcase
      case ($urandom_range(2))
        0: op.a2 = e0;
        1: op.a2 = e1;
        default: op.a2 = $urandom;
      endcase
      check_op("random", op, 1'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    drive(zero_op());
    test_reset();
    test_movs();
    test_write_hint();
    test_priority();
    test_wrap();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
